// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (package only).
// Backpressure: n/a; consumers import with pipe_ctrl_pkg::*.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID source that depends on a load currently in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall/flush decision in the top.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

  // x0 never carries a real dependency, so a load targeting it cannot stall.
  assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, optional multi-cycle mul/div stall.
// Latency: enables/flushes are combinational in the same cycle; muldiv_done is registered (one cycle after count reaches 1).
// Backpressure: stalls PC and IF/ID on load-use; freezes PC/IF/ID/ID-EX and bubbles EX/MEM while a mul/div is busy.
// Optional feature: define MULDIV_STALL_EN to add ex_muldiv_start, muldiv_done, the MD_BUSY state and its counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 8
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
`ifdef MULDIV_STALL_EN
  input  logic                   ex_muldiv_start,
`endif
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
`ifdef MULDIV_STALL_EN
  output logic                   muldiv_done,
`endif
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Reject out-of-range occupancy at elaboration time.
  if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 64) begin : g_bad_muldiv_cycles
    $error("MULDIV_CYCLES must be within 2..64");
  end

  logic                   w_load_use;
  logic                   w_busy;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  load_use_detect u_load_use_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

`ifdef MULDIV_STALL_EN
  localparam int               CNT_W    = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_md_cnt;
  logic             r_md_done;

  // Mul/div FSM: the start cycle runs normally in RUN, then MD_BUSY covers the remaining cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_md_cnt  <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (ex_muldiv_start) begin
            r_state  <= MD_BUSY;
            r_md_cnt <= CNT_LOAD;
          end
        end
        MD_BUSY: begin
          r_md_cnt <= r_md_cnt - CNT_W'(1);
          if (r_md_cnt == CNT_W'(1)) begin
            r_state   <= RUN;
            r_md_done <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign w_busy       = (r_state == MD_BUSY);
  assign muldiv_done  = r_md_done && !rst;
  assign ex_mem_flush = rst || w_busy;
`else
  assign w_busy       = 1'b0;
  assign ex_mem_flush = rst;
`endif

  // Enable/flush decode: reset, then busy, then branch flush, then load-use stall.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else if (ex_branch_taken) begin
      // The branch squashes the dependent instruction, so no stall is needed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating stall-cycle counter; reset cycles do not count as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!pc_en) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MULDIV_CYCLES, default 8, is the number of EX-stage cycles a multiply/divide occupies; legal range is 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 id_rs1, id_rs2  input  5 each  source register addresses of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  set when the ID instruction actually reads that source.
REQ-006 ex_rd  input  5  destination register of the instruction in EX.
REQ-007 ex_mem_read  input  1  set when the EX instruction is a load.
REQ-008 ex_branch_taken  input  1  taken branch or jump resolved in EX this cycle.
REQ-009 ex_muldiv_start  input  1  set when a mul/div enters EX; present only with MULDIV_STALL_EN.
REQ-010 pc_en, if_id_en, id_ex_en  output  1 each  load enables for the PC, IF/ID and ID/EX registers.
REQ-011 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  force-bubble controls for the IF/ID, ID/EX and EX/MEM registers.
REQ-012 muldiv_done  output  1  one-cycle pulse when a mul/div completes; present only with MULDIV_STALL_EN.
REQ-013 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-014 The FSM SHALL have two states, RUN and MD_BUSY; MD_BUSY exists only with MULDIV_STALL_EN.
REQ-015 load_use SHALL be ex_mem_read AND ex_rd!=0 AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).
REQ-016 In RUN with no event, all enables SHALL be 1 and all flushes SHALL be 0.
REQ-017 A taken branch in RUN (ex_branch_taken=1) SHALL drive pc_en=1, if_id_flush=1 and id_ex_flush=1; the state stays RUN.
REQ-018 A taken branch SHALL take priority over load_use and ex_muldiv_start in the same cycle: a simultaneous ex_muldiv_start is still accepted, but the younger instructions are flushed.
REQ-019 load_use in RUN without a branch SHALL drive pc_en=0, if_id_en=0 and id_ex_flush=1 for exactly that cycle.
REQ-020 No state is held for load_use; the hazard clears by itself once the bubble reaches EX.
REQ-021 ex_muldiv_start in RUN SHALL load the counter with MULDIV_CYCLES-1 and go to MD_BUSY on the next edge; that start cycle itself SHALL have normal outputs, apart from any branch or load_use effect.
REQ-022 In MD_BUSY, pc_en, if_id_en and id_ex_en SHALL be 0 and ex_mem_flush SHALL be 1.
REQ-023 In MD_BUSY the counter SHALL decrement every cycle.
REQ-024 In MD_BUSY, ex_branch_taken, load_use and ex_muldiv_start SHALL be ignored.
REQ-025 When the counter equals 1 in MD_BUSY, muldiv_done SHALL pulse on the next cycle and the state SHALL return to RUN.
REQ-026 Total EX occupancy of a mul/div SHALL therefore be MULDIV_CYCLES cycles.
REQ-027 stall_cnt SHALL increment in any cycle where pc_en=0 and rst=0, and SHALL saturate at 16'hFFFF without wrapping.
REQ-028 Counter width SHALL be ceil(log2(MULDIV_CYCLES)) bits; no wrap occurs within the legal range.

Reset
REQ-029 While rst=1, outputs SHALL be pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1 and muldiv_done=0.
REQ-030 The clock edge with rst=1 SHALL set the state to RUN, the counter to 0 and stall_cnt to 0.
REQ-031 Reset asserted in MD_BUSY SHALL abort the operation with no muldiv_done pulse; the next cycle after reset is RUN.

Configuration
REQ-032 Macro MULDIV_STALL_EN SHALL control mul/div stalling.
REQ-033 When MULDIV_STALL_EN is defined, ex_muldiv_start, muldiv_done, the MD_BUSY state and the counter SHALL exist.
REQ-034 When MULDIV_STALL_EN is undefined, the ports, state and counter SHALL be absent, ex_mem_flush SHALL be tied to rst, and the FSM SHALL reduce to RUN only.

Structure
REQ-035 Shared package pipe_ctrl_pkg SHALL hold REG_ADDR_W=5, REG_X0=5'd0, the state enum (RUN, MD_BUSY) and STALL_CNT_W=16.
REQ-036 The combinational load-use comparator SHALL be a single sub-module named load_use_detect; everything else stays in pipeline_hazard_ctrl.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, and stall_cnt increments by 1.
REQ-038 x0 filter: same as REQ-037 but ex_rd=0 -> no stall, and stall_cnt is unchanged.
REQ-039 Branch priority: ex_branch_taken=1 together with the REQ-037 hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1, and no stall.
REQ-040 Mul/div with MULDIV_CYCLES=8: a one-cycle ex_muldiv_start pulse -> 7 cycles of pc_en=0 with ex_mem_flush=1, then muldiv_done=1 for one cycle, then RUN; stall_cnt rises by 7.
REQ-041 Reset mid-operation: assert rst 3 cycles into MD_BUSY -> reset outputs per REQ-029, no muldiv_done, RUN on release, and stall_cnt=0.
REQ-042 Saturation: preload conditions so stall_cnt reaches 16'hFFFF, then apply 5 more stall cycles -> stall_cnt stays at 16'hFFFF.
